// File: rtl/sine_pkg.sv
// rtl/sine_pkg.sv - shared types and constants for the sine capture slice
//
// Purpose: capture-state encoding, default widths, sample type and window-depth helper.
// Ports:   none (package).
package sine_pkg;

  localparam int D_WIDTH_DEF = 8;
  localparam int A_WIDTH_DEF = 8;

  typedef logic [D_WIDTH_DEF-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    READOUT
  } cap_state_t;

  // Window length in samples for a given capture-address width.
  function automatic int depth_of(input int a_width);
    return 1 << a_width;
  endfunction

endpackage

// File: rtl/sine_capture_if.sv
// rtl/sine_capture_if.sv - sample input, control and readout stream bundle
//
// Purpose: groups the generator sample stream, trigger controls and the
//          valid/ready readout stream of sine_capture.
// Ports (master = host/generator side, slave = sine_capture):
//   sample_in, sample_valid, thresh, arm, abort, rd_ready : master -> slave
//   rd_data, rd_valid, rd_last, busy, triggered           : slave -> master
interface sine_capture_if #(
  parameter int D_WIDTH = 8
) ();

  logic [D_WIDTH-1:0] sample_in;
  logic               sample_valid;
  logic [D_WIDTH-1:0] thresh;
  logic               arm;
  logic               abort;
  logic [D_WIDTH-1:0] rd_data;
  logic               rd_valid;
  logic               rd_ready;
  logic               rd_last;
  logic               busy;
  logic               triggered;

  modport master (
    output sample_in, sample_valid, thresh, arm, abort, rd_ready,
    input  rd_data, rd_valid, rd_last, busy, triggered
  );

  modport slave (
    input  sample_in, sample_valid, thresh, arm, abort, rd_ready,
    output rd_data, rd_valid, rd_last, busy, triggered
  );

endinterface

// File: rtl/capture_ram.sv
// rtl/capture_ram.sv - single-clock capture window memory
//
// Purpose: one write port, one registered read port (1-cycle latency, holds
//          its output while re_i is low). No reset: contents are don't-care
//          until written by a capture.
// Ports:
//   clk_i            clock
//   we_i/waddr_i/wdata_i  synchronous write
//   re_i/raddr_i     read request; rdata_o valid the cycle after re_i
module capture_ram #(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [A_WIDTH-1:0] waddr_i,
  input  logic [D_WIDTH-1:0] wdata_i,
  input  logic               re_i,
  input  logic [A_WIDTH-1:0] raddr_i,
  output logic [D_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** A_WIDTH;

  logic [D_WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/sine_capture.sv
// rtl/sine_capture.sv - trigger-qualified capture buffer with stream readout
//
// Purpose: arms on request, triggers on a rising crossing of thresh, stores
//          DEPTH consecutive valid samples, then streams them out in order.
// Ports:
//   clk   system clock (rising edge)
//   rst   asynchronous active-low reset
//   bus   sine_capture_if.slave: sample stream, thresh/arm/abort controls,
//         rd_data/rd_valid/rd_ready/rd_last readout, busy/triggered status
module sine_capture
  import sine_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int A_WIDTH = A_WIDTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  sine_capture_if.slave   bus
);

  localparam int                 DEPTH     = depth_of(A_WIDTH);
  localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(DEPTH - 1);

  cap_state_t         state_q;
  logic [D_WIDTH-1:0] prev_s_q;
  logic               prev_ok_q;
  logic               triggered_q;
  logic               busy_q;
  logic [A_WIDTH-1:0] wr_addr_q;
  // Extra MSB marks "every word already requested from the RAM".
  logic [A_WIDTH:0]   rd_addr_q;
  // Prefetch stage: the RAM output register holds a word not yet in rd_data_q.
  logic               mid_vld_q;
  logic               mid_last_q;
  logic [D_WIDTH-1:0] rd_data_q;
  logic               rd_valid_q;
  logic               rd_last_q;

  logic               trig;
  logic               ram_we;
  logic [A_WIDTH-1:0] ram_waddr;
  logic               out_ready;
  logic               rd_issue;
  logic [D_WIDTH-1:0] ram_dout;

  // First valid sample after arming only primes prev_s (prev_ok still 0).
  assign trig = (state_q == ARMED) && bus.sample_valid && prev_ok_q &&
                (prev_s_q < bus.thresh) && (bus.sample_in >= bus.thresh);

  assign ram_we    = !bus.abort && (trig || ((state_q == CAPTURE) && bus.sample_valid));
  assign ram_waddr = (state_q == CAPTURE) ? wr_addr_q : '0;

  // Output register can take a new word when empty or being drained.
  assign out_ready = !rd_valid_q || bus.rd_ready;
  // Read ahead whenever the prefetch slot is free or will be freed this cycle.
  assign rd_issue  = (state_q == READOUT) && !rd_addr_q[A_WIDTH] &&
                     (!mid_vld_q || out_ready);

  capture_ram #(
    .A_WIDTH (A_WIDTH),
    .D_WIDTH (D_WIDTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (bus.sample_in),
    .re_i    (rd_issue),
    .raddr_i (rd_addr_q[A_WIDTH-1:0]),
    .rdata_o (ram_dout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      prev_s_q    <= '0;
      prev_ok_q   <= 1'b0;
      triggered_q <= 1'b0;
      busy_q      <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      mid_vld_q   <= 1'b0;
      mid_last_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else if (bus.abort) begin
      state_q     <= IDLE;
      triggered_q <= 1'b0;
      busy_q      <= 1'b0;
      mid_vld_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.arm) begin
            state_q     <= ARMED;
            busy_q      <= 1'b1;
            prev_ok_q   <= 1'b0;
            triggered_q <= 1'b0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
          end
        end

        ARMED: begin
          if (bus.sample_valid) begin
            prev_s_q  <= bus.sample_in;
            prev_ok_q <= 1'b1;
            if (trig) begin
              wr_addr_q   <= A_WIDTH'(1);
              triggered_q <= 1'b1;
              state_q     <= CAPTURE;
            end
          end
        end

        CAPTURE: begin
          if (bus.sample_valid) begin
            wr_addr_q <= wr_addr_q + 1'b1;
            if (wr_addr_q == LAST_ADDR) begin
              state_q <= READOUT;
            end
          end
        end

        READOUT: begin
          if (rd_issue) begin
            rd_addr_q  <= rd_addr_q + 1'b1;
            mid_last_q <= (rd_addr_q[A_WIDTH-1:0] == LAST_ADDR);
          end
          if (rd_issue) begin
            mid_vld_q <= 1'b1;
          end else if (out_ready) begin
            mid_vld_q <= 1'b0;
          end
          if (out_ready) begin
            rd_valid_q <= mid_vld_q;
            rd_last_q  <= mid_vld_q && mid_last_q;
            if (mid_vld_q) begin
              rd_data_q <= ram_dout;
            end
          end
          if (rd_valid_q && bus.rd_ready && rd_last_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.busy      = busy_q;
  assign bus.triggered = triggered_q;

endmodule

// File: tb/tb_sine_capture.sv
// tb/tb_sine_capture.sv - self-checking bench for sine_capture (A_WIDTH=4)
module tb_sine_capture;
  import sine_pkg::*;

  localparam int WIN = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;
  sample_t stim[$];

  sine_capture_if #(.D_WIDTH(8)) bus ();

  sine_capture #(.D_WIDTH(8), .A_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic make_ramp(input int start, input int len);
    stim.delete();
    for (int i = 0; i < len; i++) stim.push_back(sample_t'((start + i) & 255));
  endtask

  // Reference: first index t>=1 where the stream crosses th upward.
  function automatic int find_trigger(input int th);
    for (int k = 1; k < stim.size(); k++)
      if (int'(stim[k-1]) < th && int'(stim[k]) >= th) return k;
    return -1;
  endfunction

  // gap_mode: 0 every cycle, 1 alternate, 2 random
  // ready_mode: 0 always, 1 pattern 1,0,0,1, 2 random
  task automatic run(input int th, input int gap_mode, input int ready_mode,
                     input int abort_at, input int arm_at_rd);
    int t, fed, cyc, n, c;
    bit v, rdy, xfer;
    sample_t win[$];
    t = find_trigger(th);
    if (t < 0 || t + WIN > stim.size()) begin
      $display("FAIL stim_setup no usable trigger t=%0d", t);
      $fatal(1);
    end
    for (int i = 0; i < WIN; i++) win.push_back(stim[t+i]);

    bus.thresh = sample_t'(th);
    bus.sample_valid = 1'b0;
    bus.arm = 1'b1;
    step;
    bus.arm = 1'b0;
    chk("arm_busy", bus.busy, 1);
    chk("arm_trig_clear", bus.triggered, 0);

    fed = 0;
    cyc = 0;
    while (fed < t + WIN) begin
      if (cyc > 3000) begin
        chk("feed_timeout", 0, 1);
        return;
      end
      case (gap_mode)
        0: v = 1'b1;
        1: v = (cyc % 2) == 0;
        default: v = 1'($urandom % 2);
      endcase
      bus.sample_valid = v;
      bus.sample_in = v ? stim[fed] : sample_t'($urandom);
      bus.abort = v && (abort_at >= 0) && (fed == t + abort_at);
      step;
      cyc++;
      if (v) fed++;
      if (bus.abort) begin
        bus.abort = 1'b0;
        bus.sample_valid = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_trig", bus.triggered, 0);
        step;
        chk("abort_no_valid", bus.rd_valid, 0);
        return;
      end
      chk("cap_triggered", bus.triggered, (fed > t) ? 1 : 0);
      chk("cap_busy", bus.busy, 1);
      chk("cap_no_valid", bus.rd_valid, 0);
    end
    bus.sample_valid = 1'b0;

    n = 0;
    c = 0;
    while (n < WIN) begin
      if (c > 500) begin
        chk("read_timeout", 0, 1);
        return;
      end
      if (c < 2) chk("rd_valid_early", bus.rd_valid, 0);
      else if (c == 2) chk("rd_valid_rise", bus.rd_valid, 1);
      else if (ready_mode == 0) chk("no_bubble", bus.rd_valid, 1);
      if (bus.rd_valid) begin
        chk($sformatf("rd_data[%0d]", n), bus.rd_data, win[n]);
        chk($sformatf("rd_last[%0d]", n), bus.rd_last, (n == WIN - 1) ? 1 : 0);
      end else begin
        chk("rd_last_idle", bus.rd_last, 0);
      end
      case (ready_mode)
        0: rdy = 1'b1;
        1: rdy = (c % 4 == 0) || (c % 4 == 3);
        default: rdy = 1'($urandom % 2);
      endcase
      bus.rd_ready = rdy;
      bus.arm = (c == arm_at_rd);
      xfer = bus.rd_valid && rdy;
      step;
      c++;
      bus.arm = 1'b0;
      if (xfer) n++;
      chk("rd_busy", bus.busy, (n < WIN) ? 1 : 0);
    end
    bus.rd_ready = 1'b1;
    chk("post_valid", bus.rd_valid, 0);
    step;
    chk("post_busy", bus.busy, 0);
    chk("post_valid2", bus.rd_valid, 0);
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    int th;
    bus.sample_in = '0;
    bus.sample_valid = 1'b0;
    bus.thresh = '0;
    bus.arm = 1'b0;
    bus.abort = 1'b0;
    bus.rd_ready = 1'b0;

    #2 rst = 1'b0;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.rd_valid, 0);
    chk("rst_last", bus.rd_last, 0);
    chk("rst_trig", bus.triggered, 0);
    chk("rst_data", bus.rd_data, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    step;

    // Basic ramp capture, streaming readout.
    make_ramp(0, 40);
    run(10, 0, 0, -1, -1);

    // Asynchronous reset in the middle of a capture.
    make_ramp(0, 40);
    bus.thresh = 8'd10;
    bus.arm = 1'b1;
    step;
    bus.arm = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.sample_valid = 1'b1;
      bus.sample_in = stim[i];
      step;
    end
    bus.sample_valid = 1'b0;
    chk("pre_rst_trig", bus.triggered, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_valid", bus.rd_valid, 0);
    chk("mid_rst_trig", bus.triggered, 0);
    chk("mid_rst_data", bus.rd_data, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    step;

    // First-sample guard: armed at 50, trigger only on the 9->10 wrap crossing.
    make_ramp(50, 240);
    run(10, 0, 0, -1, -1);

    // Gapped input and stalled output.
    make_ramp(0, 40);
    run(10, 1, 1, -1, -1);

    // Equality trigger then abort on the 5th capture write, then clean re-capture.
    make_ramp(9, 40);
    run(10, 0, 0, 5, -1);
    make_ramp(200, 40);
    run(210, 0, 0, -1, -1);

    // arm pulsed during readout is ignored.
    make_ramp(100, 40);
    run(120, 0, 1, -1, 5);

    // Randomized streams, thresholds, gaps and back-pressure.
    for (int r = 0; r < 3; r++) begin
      th = $urandom_range(1, 255);
      stim.delete();
      for (int i = 0; i < 40; i++) stim.push_back(sample_t'($urandom));
      stim.push_back(sample_t'(th - 1));
      stim.push_back(sample_t'(th));
      for (int i = 0; i < 20; i++) stim.push_back(sample_t'($urandom));
      run(th, 2, 2, -1, -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sine_capture.md
# sine_capture

Trigger-qualified capture buffer directly downstream of the sine generator. It watches the registered ROM sample stream and arms on request. On a rising crossing of a programmable threshold it stores a fixed-length window of consecutive valid samples, then streams the window out over a valid/ready interface for a host or UART stage.

## Interface
- D_WIDTH, 8, sample width; matches the generator's dout width.
- A_WIDTH, 8, capture-address width; window length DEPTH = 2**A_WIDTH samples.
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-low reset; one clock, no other clock domains.
- sample_in  in  D_WIDTH  unsigned sample from the generator ROM output.
- sample_valid  in  1  qualifies sample_in; it is the generator's en delayed one cycle to match the ROM latency.
- thresh  in  D_WIDTH  unsigned trigger level; sampled every cycle.
- arm  in  1  single-cycle request to start a capture.
- abort  in  1  return to IDLE from any state.
- rd_data  out  D_WIDTH  captured sample being offered.
- rd_valid  out  1  rd_data is valid.
- rd_ready  in  1  consumer accepts rd_data this cycle.
- rd_last  out  1  the offered word is sample DEPTH-1.
- busy  out  1  state is not IDLE.
- triggered  out  1  a trigger occurred in the current capture; it clears on arm or abort.

## Operation
- States: IDLE, ARMED, CAPTURE, READOUT.
- IDLE: arm moves the FSM to ARMED. It also clears prev_ok, triggered, wr_addr and rd_addr.
- ARMED: on each sample_valid, prev_s <= sample_in and prev_ok <= 1. The trigger condition is sample_valid && prev_ok && prev_s < thresh && sample_in >= thresh, with unsigned compare.
  - The first valid sample after arming never triggers.
  - Equality with thresh counts as crossed.
- On trigger:
  - The triggering sample is written at address 0.
  - wr_addr becomes 1, triggered is set, and the FSM enters CAPTURE.
- CAPTURE: each sample_valid writes sample_in at wr_addr and increments it. The write at address DEPTH-1 moves the FSM to READOUT. wr_addr wraps to 0 and is unused afterwards.
  - Gaps in sample_valid simply stall capture; samples are never dropped or padded.
- READOUT: words 0..DEPTH-1 are presented in order. A word transfers when rd_valid && rd_ready. The transfer with rd_last moves the FSM to IDLE.
- arm outside IDLE is ignored. abort has priority over arm, trigger and transfers, and takes effect at the next edge.
- Stored RAM contents are not cleared by abort or reset and must never be observable: rd_valid is only asserted in READOUT.

## Timing
- Reset values:
  - state is IDLE.
  - rd_valid, rd_last, busy and triggered are 0.
  - rd_data is 0.
  - wr_addr, rd_addr, prev_s and prev_ok are 0.
- RAM: synchronous write; synchronous read with 1-cycle latency.
- Arm-to-trigger: trigger is evaluated in the same cycle as the qualifying sample. busy is high from the cycle after arm.
- READOUT entry: rd_valid rises exactly 2 cycles after the edge that enters READOUT (RAM read, then output register).
- Streaming: with rd_ready held high, one word transfers per cycle with no bubbles. A one-entry prefetch/skid register hides the RAM latency.
- Stall: while rd_valid && !rd_ready, rd_data and rd_last hold stable.
- rd_last is high only together with rd_valid on word DEPTH-1.
- busy falls the cycle after the last transfer. A new arm is then accepted.
- Reset asserted mid-operation clears all state asynchronously. Outputs reach reset values without waiting for a clock edge.

## Structure
- Shared package sine_pkg:
  - typedef enum cap_state_t {IDLE, ARMED, CAPTURE, READOUT}.
  - Sample typedef sample_t of D_WIDTH.
  - localparam DEPTH derivation.
- One sub-module: capture_ram. It is parameterised by A_WIDTH and D_WIDTH, with a single clock, one write port and one registered read port. It has no reset, since its contents are don't-care.
- FSM, trigger comparator, address counters and output skid register live in sine_capture.

## Test plan
- Reset: rst low mid-CAPTURE (A_WIDTH=4) -> busy, rd_valid, triggered and rd_data all 0 immediately. After release, arm is accepted and a fresh capture starts at address 0.
- Basic capture: ramp 0,1,2,… with sample_valid every cycle, thresh=10, A_WIDTH=4, rd_ready=1. Expected: triggered goes high on sample 10, then 16 words 10..25 stream out back-to-back, rd_last is high on 25 only, and busy falls the cycle after.
- First-sample guard: arm while the ramp is at 50, thresh=10 -> no trigger until the ramp wraps past 255 and crosses 9→10. The window starts at 10.
- Gapped input and stalled output: sample_valid high on alternate cycles; rd_ready toggles 1,0,0,1. Expected: the stored window contains contiguous valid samples only, rd_data holds during stalls, and exactly 16 transfers occur.
- Equality and abort: samples 9,10 with thresh=10 -> trigger on 10. abort on the 5th CAPTURE write -> IDLE and triggered=0 the next cycle; a subsequent arm starts a clean capture.
- Arm ignored: pulse arm during READOUT -> readout completes unchanged, and the FSM returns to IDLE, not ARMED.
